// File: rtl/doodle_pkg.sv
// doodle_pkg: shared definitions for the doodle platform manager.
//   - state_e      : one-hot states ST_IDLE / ST_LOAD / ST_RUN
//   - LFSR_TAPS    : feedback mask of the 16-bit Fibonacci LFSR (taps 16, 14, 13, 11)
//   - DEF_SCREEN_H : default screen height in rows
//   - DEF_XMAX     : default largest legal platform x
//   - lfsr_step()  : one LFSR shift
//   - xpick()      : folds an 8-bit random value into 0..xmax
package doodle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_LOAD = 3'b010,
    ST_RUN  = 3'b100
  } state_e;

  // Bits 15, 13, 12, 10 correspond to taps 16, 14, 13, 11.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [7:0]  DEF_SCREEN_H = 8'd200;
  localparam logic [7:0]  DEF_XMAX     = 8'd128;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] xpick(input logic [7:0] v, input logic [7:0] xmax);
    logic [8:0] lim;
    lim = {1'b0, xmax} + 9'd1;
    if ({1'b0, v} > {1'b0, xmax}) begin
      return 8'({1'b0, v} - lim);
    end
    return v;
  endfunction

endpackage

// File: rtl/doodle_lfsr16.sv
// doodle_lfsr16: 16-bit Fibonacci LFSR that can advance several steps per cycle.
// Ports:
//   Clk   in            clock
//   reset in            asynchronous, active-high; loads seed
//   adv   in  [ADV_W]   number of steps to advance this cycle (0..MAX_ADV)
//   seed  in  [16]      reset value (must be nonzero)
//   value out [16]      current LFSR state
module doodle_lfsr16
  import doodle_pkg::*;
#(
  parameter int unsigned MAX_ADV = 4,
  localparam int unsigned ADV_W = $clog2(MAX_ADV + 1)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [ADV_W-1:0] adv,
  input  logic [15:0]      seed,
  output logic [15:0]      value
);

  logic [15:0] r_state;
  logic [15:0] w_next;

  always_comb begin
    w_next = r_state;
    for (int i = 0; i < int'(MAX_ADV); i++) begin
      if (ADV_W'(i) < adv) begin
        w_next = lfsr_step(w_next);
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state <= seed;
    end else begin
      r_state <= w_next;
    end
  end

  assign value = r_state;

endmodule

// File: rtl/doodle_platforms.sv
// doodle_platforms: platform manager and collision detector for the doodle game.
// Holds NUM_PLAT platforms, loads a field on Start, respawns platforms that scroll
// off the bottom, and on each Tick tests the falling doodle against every platform.
// Optional feature macro: DOODLE_PLAT_HITCNT_EN adds a saturating hit_count output.
// Ports:
//   Clk, reset           clock, asynchronous active-high reset
//   Start                load a new platform field
//   Tick                 one-cycle game-step strobe (collision test)
//   Scroll               one-cycle strobe, field moves down one row
//   q_Down               doodle is falling
//   doodle_x, doodle_y   doodle left edge and feet row
//   Ready                field loaded, in RUN
//   Hit                  one-cycle landing pulse
//   Bottom               doodle at row 0 without a hit (held until next Tick/Start)
//   plat_x, plat_y       packed platform positions, platform k at [8k+7:8k]
//   hit_count            (DOODLE_PLAT_HITCNT_EN only) saturating count of Hit pulses
module doodle_platforms
  import doodle_pkg::*;
#(
  parameter int unsigned NUM_PLAT = 4,
  parameter logic [7:0]  SCREEN_H = DEF_SCREEN_H,
  parameter logic [7:0]  GAP      = 8'd48,
  parameter logic [7:0]  PLAT_W   = 8'd32,
  parameter logic [7:0]  DOODLE_W = 8'd16,
  parameter logic [7:0]  XMAX     = DEF_XMAX,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  Tick,
  input  logic                  Scroll,
  input  logic                  q_Down,
  input  logic [7:0]            doodle_x,
  input  logic [7:0]            doodle_y,
  output logic                  Ready,
  output logic                  Hit,
  output logic                  Bottom,
  output logic [8*NUM_PLAT-1:0] plat_x,
  output logic [8*NUM_PLAT-1:0] plat_y
`ifdef DOODLE_PLAT_HITCNT_EN
  ,
  output logic [7:0]            hit_count
`endif
);

  localparam int unsigned ADV_W = $clog2(NUM_PLAT + 1);
  localparam int unsigned IDX_W = 3;

  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_ready;
  logic             r_hit;
  logic             r_bottom;
  logic [7:0]       r_px [NUM_PLAT];
  logic [7:0]       r_py [NUM_PLAT];
`ifdef DOODLE_PLAT_HITCNT_EN
  logic [7:0]       r_hit_cnt;
`endif

  logic [15:0]      w_lfsr;
  logic [ADV_W-1:0] w_adv;
  logic             w_hit;
  logic [7:0]       w_load_x;
  logic [7:0]       w_load_y;
  logic [7:0]       w_scr_x [NUM_PLAT];
  logic [7:0]       w_scr_y [NUM_PLAT];
  logic [ADV_W-1:0] w_scr_adv;
  logic [15:0]      w_chain;

  doodle_lfsr16 #(
    .MAX_ADV(NUM_PLAT)
  ) u_lfsr (
    .Clk  (Clk),
    .reset(reset),
    .adv  (w_adv),
    .seed (SEED),
    .value(w_lfsr)
  );

  // Collision against the registered (pre-scroll) positions; sums in 9 bits.
  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < int'(NUM_PLAT); k++) begin
      if (q_Down && (doodle_y == r_py[k]) &&
          (({1'b0, doodle_x} + {1'b0, DOODLE_W}) > {1'b0, r_px[k]}) &&
          ({1'b0, doodle_x} < ({1'b0, r_px[k]} + {1'b0, PLAT_W}))) begin
        w_hit = 1'b1;
      end
    end
  end

  // Scroll: respawns walk the LFSR sequence in ascending platform order.
  always_comb begin
    w_chain   = w_lfsr;
    w_scr_adv = '0;
    for (int k = 0; k < int'(NUM_PLAT); k++) begin
      if (r_py[k] == 8'd0) begin
        w_scr_y[k] = SCREEN_H - 8'd1;
        w_scr_x[k] = xpick(w_chain[7:0], XMAX);
        w_chain    = lfsr_step(w_chain);
        w_scr_adv  = w_scr_adv + ADV_W'(1);
      end else begin
        w_scr_y[k] = r_py[k] - 8'd1;
        w_scr_x[k] = r_px[k];
      end
    end
  end

  always_comb begin
    w_load_x = xpick(w_lfsr[7:0], XMAX);
    w_load_y = 8'(32'(r_idx) * 32'(GAP));
    w_adv    = '0;
    if (!Start) begin
      if (r_state == ST_LOAD) begin
        w_adv = ADV_W'(1);
      end else if ((r_state == ST_RUN) && Scroll) begin
        w_adv = w_scr_adv;
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_ready  <= 1'b0;
      r_hit    <= 1'b0;
      r_bottom <= 1'b0;
      for (int k = 0; k < int'(NUM_PLAT); k++) begin
        r_px[k] <= 8'd0;
        r_py[k] <= 8'd0;
      end
`ifdef DOODLE_PLAT_HITCNT_EN
      r_hit_cnt <= 8'd0;
`endif
    end else begin
      r_hit <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
          end
        end
        ST_LOAD: begin
          if (Start) begin
            r_idx <= '0;
          end else begin
            for (int k = 0; k < int'(NUM_PLAT); k++) begin
              if (r_idx == IDX_W'(k)) begin
                r_px[k] <= w_load_x;
                r_py[k] <= w_load_y;
              end
            end
            if (r_idx == IDX_W'(NUM_PLAT - 1)) begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        ST_RUN: begin
          if (Start) begin
            r_state  <= ST_LOAD;
            r_idx    <= '0;
            r_ready  <= 1'b0;
            r_bottom <= 1'b0;
          end else begin
            if (Tick) begin
              r_hit    <= w_hit;
              r_bottom <= q_Down && (doodle_y == 8'd0) && !w_hit;
            end
            if (Scroll) begin
              for (int k = 0; k < int'(NUM_PLAT); k++) begin
                r_px[k] <= w_scr_x[k];
                r_py[k] <= w_scr_y[k];
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
`ifdef DOODLE_PLAT_HITCNT_EN
      if (Start) begin
        r_hit_cnt <= 8'd0;
      end else if ((r_state == ST_RUN) && Tick && w_hit && (r_hit_cnt != 8'd255)) begin
        r_hit_cnt <= r_hit_cnt + 8'd1;
      end
`endif
    end
  end

  always_comb begin
    plat_x = '0;
    plat_y = '0;
    for (int k = 0; k < int'(NUM_PLAT); k++) begin
      plat_x[8*k +: 8] = r_px[k];
      plat_y[8*k +: 8] = r_py[k];
    end
  end

  assign Ready  = r_ready;
  assign Hit    = r_hit;
  assign Bottom = r_bottom;
`ifdef DOODLE_PLAT_HITCNT_EN
  assign hit_count = r_hit_cnt;
`endif

endmodule

// File: tb/tb_doodle_platforms.sv
// Self-checking bench for doodle_platforms: hand tables and sequences for the
// corner cases, plus randomized traffic compared against a behavioural model.
module tb_doodle_platforms;

  localparam int          NP   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic Clk = 1'b0;
  logic reset, Start, Tick, Scroll, q_Down;
  logic [7:0] doodle_x, doodle_y;
  logic Ready, Hit, Bottom;
  logic [8*NP-1:0] plat_x, plat_y;
`ifdef DOODLE_PLAT_HITCNT_EN
  logic [7:0] hit_count;
`endif

  always #5 Clk = ~Clk;

  doodle_platforms #(
    .NUM_PLAT(NP),
    .SCREEN_H(8'd200),
    .GAP     (8'd48),
    .PLAT_W  (8'd32),
    .DOODLE_W(8'd16),
    .XMAX    (8'd128),
    .SEED    (SEED)
  ) dut (
    .Clk      (Clk),
    .reset    (reset),
    .Start    (Start),
    .Tick     (Tick),
    .Scroll   (Scroll),
    .q_Down   (q_Down),
    .doodle_x (doodle_x),
    .doodle_y (doodle_y),
    .Ready    (Ready),
    .Hit      (Hit),
    .Bottom   (Bottom),
    .plat_x   (plat_x),
    .plat_y   (plat_y)
`ifdef DOODLE_PLAT_HITCNT_EN
    ,
    .hit_count(hit_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: 0 = idle, 1 = loading, 2 = running.
  int          m_mode;
  int          m_idx;
  int          m_x [NP];
  int          m_y [NP];
  logic [15:0] m_lfsr;
  bit          m_ready, m_hit, m_bottom;
  int          m_cnt;

  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int xval(logic [15:0] s);
    int v;
    v = int'(s[7:0]);
    return (v > 128) ? v - 129 : v;
  endfunction

  function automatic logic [31:0] pack_x();
    logic [31:0] p;
    for (int k = 0; k < NP; k++) p[8*k +: 8] = 8'(m_x[k]);
    return p;
  endfunction

  function automatic logic [31:0] pack_y();
    logic [31:0] p;
    for (int k = 0; k < NP; k++) p[8*k +: 8] = 8'(m_y[k]);
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_lfsr = SEED;
    m_ready = 0; m_hit = 0; m_bottom = 0; m_cnt = 0;
    for (int k = 0; k < NP; k++) begin m_x[k] = 0; m_y[k] = 0; end
  endtask

  task automatic model_step(bit st, bit tk, bit sc, bit qd, int dx, int dy);
    bit h;
    m_hit = 0;
    if (st) m_cnt = 0;
    if (m_mode == 0) begin
      if (st) begin m_mode = 1; m_idx = 0; end
    end else if (m_mode == 1) begin
      if (st) m_idx = 0;
      else begin
        m_x[m_idx] = xval(m_lfsr);
        m_y[m_idx] = m_idx * 48;
        m_lfsr = lfsr_next(m_lfsr);
        if (m_idx == NP - 1) begin m_mode = 2; m_ready = 1; end
        else m_idx++;
      end
    end else begin
      if (st) begin
        m_mode = 1; m_idx = 0; m_ready = 0; m_bottom = 0;
      end else begin
        if (tk) begin
          h = 0;
          for (int k = 0; k < NP; k++)
            if (qd && dy == m_y[k] && dx + 16 > m_x[k] && dx < m_x[k] + 32) h = 1;
          m_hit = h;
          m_bottom = qd && dy == 0 && !h;
          if (h && m_cnt < 255) m_cnt++;
        end
        if (sc) begin
          for (int k = 0; k < NP; k++) begin
            if (m_y[k] == 0) begin
              m_y[k] = 199;
              m_x[k] = xval(m_lfsr);
              m_lfsr = lfsr_next(m_lfsr);
            end else m_y[k]--;
          end
        end
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("ready", 32'(Ready), 32'(m_ready));
    check("hit", 32'(Hit), 32'(m_hit));
    check("bottom", 32'(Bottom), 32'(m_bottom));
    check("plat_x", plat_x, pack_x());
    check("plat_y", plat_y, pack_y());
`ifdef DOODLE_PLAT_HITCNT_EN
    check("hit_count", 32'(hit_count), 32'(m_cnt));
`endif
  endtask

  task automatic step(bit st, bit tk, bit sc, bit qd, int dx, int dy);
    Start = st; Tick = tk; Scroll = sc; q_Down = qd;
    doodle_x = 8'(dx); doodle_y = 8'(dy);
    @(posedge Clk);
    model_step(st, tk, sc, qd, dx, dy);
    #1;
    check_all();
    Start = 0; Tick = 0; Scroll = 0;
  endtask

  task automatic load_field(output int cyc);
    step(1, 0, 0, 0, 200, 255);
    cyc = 1;
    while (!Ready && cyc < 20) begin
      step(0, 0, 0, 0, 200, 255);
      cyc++;
    end
  endtask

  typedef struct {
    int dy;
    int dx;
    bit rel;
    bit qd;
    bit exp_hit;
    bit exp_bottom;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, p, dx, dy, k;
    logic [31:0] first_x;
    bit st, tk, sc, qd;

    tbl[0]  = '{48, -10, 1, 1, 1, 0};
    tbl[1]  = '{48,  32, 1, 1, 0, 0};
    tbl[2]  = '{48,  31, 1, 1, 1, 0};
    tbl[3]  = '{48, -15, 1, 1, 1, 0};
    tbl[4]  = '{48, -16, 1, 1, 0, 0};
    tbl[5]  = '{48,   0, 1, 0, 0, 0};
    tbl[6]  = '{47,   0, 1, 1, 0, 0};
    tbl[7]  = '{ 0, 200, 0, 1, 0, 1};
    tbl[8]  = '{ 5, 200, 0, 1, 0, 0};
    tbl[9]  = '{ 0, 200, 0, 0, 0, 0};
    tbl[10] = '{ 0, 200, 0, 1, 0, 1};

    reset = 1; Start = 0; Tick = 0; Scroll = 0; q_Down = 0;
    doodle_x = 0; doodle_y = 0;
    model_reset();
    #1;
    check("rst_ready", 32'(Ready), 0);
    check("rst_hit", 32'(Hit), 0);
    check("rst_bottom", 32'(Bottom), 0);
    check("rst_plat_x", plat_x, 0);
    check("rst_plat_y", plat_y, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    reset = 0;

    // Load: Ready in cycle NUM_PLAT+1, y = k*GAP, x within 0..XMAX.
    load_field(cyc);
    check("ready_cycle", 32'(cyc), 5);
    check("load_plat_y", plat_y, 32'h9060_3000);
    k = 0;
    for (int i = 0; i < NP; i++) if (plat_x[8*i +: 8] > 8'd128) k++;
    check("load_x_range", 32'(k), 0);
    first_x = plat_x;

    for (int r = 0; r < 20 && m_x[1] < 16; r++) load_field(cyc);
    check("p1_x_usable", 32'(plat_x[15:8] >= 8'd16), 1);

    // Collision table against platform 1 (y = 48).
    p = m_x[1];
    foreach (tbl[i]) begin
      dx = tbl[i].rel ? p + tbl[i].dx : tbl[i].dx;
      step(0, 1, 0, tbl[i].qd, dx, tbl[i].dy);
      check($sformatf("tbl%0d_hit", i), 32'(Hit), 32'(tbl[i].exp_hit));
      check($sformatf("tbl%0d_bottom", i), 32'(Bottom), 32'(tbl[i].exp_bottom));
      step(0, 0, 0, tbl[i].qd, dx, tbl[i].dy);
      check($sformatf("tbl%0d_pulse", i), 32'(Hit), 0);
      check($sformatf("tbl%0d_hold", i), 32'(Bottom), 32'(tbl[i].exp_bottom));
    end

    // Scroll with platform 0 at y=0: respawn at 199, others decrement.
    step(0, 0, 1, 0, 200, 255);
    check("scroll_y", plat_y, 32'h8F5F_2FC7);

    // Tick and Scroll together: collision sees pre-scroll y (47 for platform 1).
    step(0, 1, 1, 1, m_x[1], 47);
    check("ts_hit", 32'(Hit), 1);
    check("ts_y", plat_y, 32'h8E5E_2EC6);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      st = ($urandom_range(0, 63) == 0);
      tk = $urandom_range(0, 1) == 1;
      sc = ($urandom_range(0, 3) == 0);
      qd = ($urandom_range(0, 3) != 0);
      k  = int'($urandom_range(0, NP - 1));
      case ($urandom_range(0, 9))
        0: dy = 0;
        1, 2, 3, 4: dy = m_y[k];
        default: dy = int'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        dx = m_x[k] + int'($urandom_range(0, 47)) - 16;
        if (dx < 0) dx = 0;
      end else dx = int'($urandom_range(0, 255));
      step(st, tk, sc, qd, dx, dy);
    end

`ifdef DOODLE_PLAT_HITCNT_EN
    load_field(cyc);
    check("cnt_after_start", 32'(hit_count), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, m_x[1], m_y[1]);
      step(0, 0, 0, 0, 200, 255);
    end
    check("cnt_three", 32'(hit_count), 3);
    step(1, 0, 0, 0, 200, 255);
    check("cnt_cleared", 32'(hit_count), 0);
`endif

    // Reset asserted in the second LOAD cycle.
    if (Ready) step(1, 0, 0, 0, 200, 255);
    else begin
      while (m_mode != 0) step(0, 0, 0, 0, 200, 255);
      step(1, 0, 0, 0, 200, 255);
    end
    step(0, 0, 0, 0, 200, 255);
    #2;
    reset = 1;
    #1;
    model_reset();
    check("mid_rst_ready", 32'(Ready), 0);
    check("mid_rst_hit", 32'(Hit), 0);
    check("mid_rst_bottom", 32'(Bottom), 0);
    check("mid_rst_plat_x", plat_x, 0);
    check("mid_rst_plat_y", plat_y, 0);
    @(negedge Clk);
    reset = 0;
    step(0, 0, 0, 0, 200, 255);
    check("idle_stays", 32'(Ready), 0);
    load_field(cyc);
    check("reload_cycle", 32'(cyc), 5);
    check("reload_same_x", plat_x, first_x);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
